nrisc_mem_sequencer: RTL and testbench

- Multicycle sequencer and arbiter placing the 8-bit nRisc core on one unified single-port synchronous RAM.
- The RAM replaces the separate instruction and data memories.
- Each instruction runs as fetch, optional data access, then commit. The core advances only on a one-cycle cpu_step pulse.
- A loader port (boot/debug) shares the RAM and is granted only between instructions.

---
 rtl/nrisc_mem_sequencer.sv | 140 ++++++++++++++
 tb/tb_nrisc_mem_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_mem_sequencer.sv
// Multicycle sequencer putting the nRisc core and a boot/debug loader on one
// single-port synchronous RAM: fetch, optional data access, then a commit pulse.
module nrisc_mem_sequencer #(
  parameter logic [7:0] DATA_BASE = 8'h80
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  input  logic [7:0]  cpu_pc,
  input  logic [7:0]  cpu_endereco,
  input  logic [7:0]  cpu_dado_escrita,
  input  logic        cpu_ler,
  input  logic        cpu_escrever,
  output logic [7:0]  cpu_instr,
  output logic [7:0]  cpu_dado_lido,
  output logic        cpu_step,
  input  logic        ldr_req,
  input  logic        ldr_we,
  input  logic [7:0]  ldr_addr,
  input  logic [7:0]  ldr_wdata,
  output logic        ldr_gnt,
  output logic [7:0]  ldr_rdata,
  output logic        ldr_valid,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] instr_count,
  output logic        proto_err
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_WAIT,
    S_DECODE,
    S_DATA_RD,
    S_DATA_RD_WAIT,
    S_DATA_WR,
    S_STEP,
    S_LDR,
    S_LDR_WAIT
  } state_t;

  state_t     state;
  logic [7:0] data_addr;

  // Core data addresses are relative to the data window; the sum wraps in 8 bits.
  assign data_addr = cpu_endereco + DATA_BASE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      cpu_instr     <= '0;
      cpu_dado_lido <= '0;
      ldr_rdata     <= '0;
      ldr_valid     <= 1'b0;
      instr_count   <= '0;
      proto_err     <= 1'b0;
    end else begin
      ldr_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ldr_req)  state <= S_LDR;
          else if (run) state <= S_FETCH;
        end
        S_FETCH: state <= S_FETCH_WAIT;
        S_FETCH_WAIT: begin
          cpu_instr <= mem_rdata;
          state     <= S_DECODE;
        end
        S_DECODE: begin
          if (cpu_ler) begin
            if (cpu_escrever) proto_err <= 1'b1;
            state <= S_DATA_RD;
          end else if (cpu_escrever) begin
            state <= S_DATA_WR;
          end else begin
            state <= S_STEP;
          end
        end
        S_DATA_RD: state <= S_DATA_RD_WAIT;
        S_DATA_RD_WAIT: begin
          cpu_dado_lido <= mem_rdata;
          state         <= S_STEP;
        end
        S_DATA_WR: state <= S_STEP;
        S_STEP: begin
          instr_count <= instr_count + 16'd1;
          if (ldr_req)  state <= S_LDR;
          else if (run) state <= S_FETCH;
          else          state <= S_IDLE;
        end
        S_LDR: state <= ldr_we ? S_IDLE : S_LDR_WAIT;
        S_LDR_WAIT: begin
          // Valid pulse is registered alongside ldr_rdata so the two line up.
          ldr_rdata <= mem_rdata;
          ldr_valid <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_step  = 1'b0;
    ldr_gnt   = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_addr = cpu_pc;
        mem_re   = 1'b1;
      end
      S_DATA_RD: begin
        mem_addr = data_addr;
        mem_re   = 1'b1;
      end
      S_DATA_WR: begin
        mem_addr  = data_addr;
        mem_wdata = cpu_dado_escrita;
        mem_we    = 1'b1;
      end
      S_STEP: cpu_step = 1'b1;
      S_LDR: begin
        ldr_gnt   = 1'b1;
        mem_addr  = ldr_addr;
        mem_wdata = ldr_wdata;
        mem_we    = ldr_we;
        mem_re    = ~ldr_we;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_nrisc_mem_sequencer.sv
// Bench for nrisc_mem_sequencer: RAM and core stand-ins plus an instruction-level
// reference model (fetch/load/store semantics, cycle counts, retire count).
module tb_nrisc_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset, run;
  logic [7:0]  cpu_pc, cpu_endereco, cpu_dado_escrita;
  logic        cpu_ler, cpu_escrever;
  logic [7:0]  cpu_instr, cpu_dado_lido;
  logic        cpu_step;
  logic        ldr_req, ldr_we;
  logic [7:0]  ldr_addr, ldr_wdata;
  logic        ldr_gnt;
  logic [7:0]  ldr_rdata;
  logic        ldr_valid;
  logic [7:0]  mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [7:0]  mem_rdata;
  logic [15:0] instr_count;
  logic        proto_err;

  logic        pre_we;
  logic [7:0]  pre_addr, pre_data;
  logic [7:0]  ram   [256];
  logic [7:0]  model [256];
  logic [15:0] exp_count;
  logic        exp_proto;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clock = ~clock;

  // Instruction encoding used by this bench: bit6 = load, bit7 = store.
  assign cpu_ler      = cpu_instr[6];
  assign cpu_escrever = cpu_instr[7];

  always @(posedge clock) begin
    if (pre_we)      ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  nrisc_mem_sequencer #(.DATA_BASE(8'h80)) dut (
    .clock(clock), .reset(reset), .run(run),
    .cpu_pc(cpu_pc), .cpu_endereco(cpu_endereco), .cpu_dado_escrita(cpu_dado_escrita),
    .cpu_ler(cpu_ler), .cpu_escrever(cpu_escrever),
    .cpu_instr(cpu_instr), .cpu_dado_lido(cpu_dado_lido), .cpu_step(cpu_step),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_gnt(ldr_gnt), .ldr_rdata(ldr_rdata), .ldr_valid(ldr_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .instr_count(instr_count), .proto_err(proto_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_out();
    return {2'b00, cpu_instr, cpu_dado_lido, cpu_step, ldr_gnt, ldr_rdata, ldr_valid,
            mem_addr, mem_wdata, mem_we, mem_re, instr_count, proto_err};
  endfunction

  // Random byte that never decodes as load+store.
  function automatic logic [7:0] nc_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b[7:6] == 2'b11) b[7] = 1'b0;
    return b;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(negedge clock);
    pre_we   = 1'b0;
    model[a] = d;
  endtask

  // Executes one instruction at cpu_pc and checks it against the model.
  task automatic run_one(input string tag, input bit raise_ldr, output int fetch_at);
    logic [7:0] ins, daddr, waddr, wdat, raddr;
    logic [1:0] kind;
    int t, n, exp_len;
    bit stepped, wr_seen, rd_seen;
    ins     = model[cpu_pc];
    kind    = ins[7:6];
    daddr   = 8'((int'(cpu_endereco) + 128) % 256);
    exp_len = (kind == 2'b00) ? 4 : (kind == 2'b10) ? 5 : 6;
    t = -1; n = 0; stepped = 0; wr_seen = 0; rd_seen = 0; fetch_at = -1;
    waddr = '0; wdat = '0; raddr = '0;
    while (!stepped && n < 30) begin
      @(negedge clock);
      n++;
      if (t < 0) begin
        if (mem_re) begin
          t = 0;
          fetch_at = n;
          check({tag, ".fetch_addr"}, 64'(mem_addr), 64'(cpu_pc));
        end
      end else begin
        t++;
        if (mem_re) begin rd_seen = 1; raddr = mem_addr; end
      end
      if (mem_we) begin wr_seen = 1; waddr = mem_addr; wdat = mem_wdata; end
      if (raise_ldr && t == 4) ldr_req = 1'b1;
      if (cpu_step) stepped = 1;
    end
    check({tag, ".step_seen"}, 64'(stepped), 64'(1));
    check({tag, ".cycles"}, 64'(t + 1), 64'(exp_len));
    check({tag, ".instr"}, 64'(cpu_instr), 64'(ins));
    check({tag, ".write"}, 64'(wr_seen), 64'(kind == 2'b10));
    if (kind == 2'b10) begin
      check({tag, ".waddr"}, 64'(waddr), 64'(daddr));
      check({tag, ".wdata"}, 64'(wdat), 64'(cpu_dado_escrita));
      model[daddr] = cpu_dado_escrita;
    end
    check({tag, ".read"}, 64'(rd_seen), 64'(kind[0]));
    if (kind[0]) begin
      check({tag, ".raddr"}, 64'(raddr), 64'(daddr));
      check({tag, ".load"}, 64'(cpu_dado_lido), 64'(model[daddr]));
    end
    if (kind == 2'b11) exp_proto = 1'b1;
    check({tag, ".proto"}, 64'(proto_err), 64'(exp_proto));
    check({tag, ".count"}, 64'(instr_count), 64'(exp_count));
    exp_count = exp_count + 16'd1;
    cpu_pc    = cpu_pc + 8'd1;
  endtask

  // Loader access; returns how many cycles the grant took.
  task automatic ldr_op(input string tag, input bit we, input logic [7:0] a,
                        input logic [7:0] d, output int gnt_at);
    int n;
    bit seen;
    ldr_we = we; ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
    n = 0; seen = 0; gnt_at = -1;
    while (!seen && n < 20) begin
      @(negedge clock);
      n++;
      if (ldr_gnt) begin
        seen = 1;
        gnt_at = n;
        check({tag, ".mem"}, 64'({mem_we, mem_re, mem_addr}), 64'({we, ~we, a}));
        if (we) check({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(d));
      end
    end
    ldr_req = 1'b0;
    check({tag, ".gnt_seen"}, 64'(seen), 64'(1));
    if (we) begin
      model[a] = d;
    end else begin
      seen = 0; n = 0;
      while (!seen && n < 3) begin
        @(negedge clock);
        n++;
        if (ldr_valid) seen = 1;
      end
      check({tag, ".valid_seen"}, 64'(seen), 64'(1));
      check({tag, ".rdata"}, 64'(ldr_rdata), 64'(model[a]));
    end
  endtask

  initial begin
    int f;
    bit seen;
    reset = 1'b1; run = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    cpu_pc = '0; cpu_endereco = '0; cpu_dado_escrita = '0;
    ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0; ldr_wdata = '0;
    exp_count = '0; exp_proto = 1'b0;

    for (int i = 0; i < 256; i++) poke(8'(i), nc_byte());
    check("reset_outputs", all_out(), 64'(0));
    reset = 1'b0;

    // Reset while a store is on the RAM port must kill the write at once.
    poke(8'h00, 8'h80);
    cpu_endereco = 8'h10; cpu_dado_escrita = 8'hEE; run = 1'b1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (mem_we) seen = 1;
    end
    check("rst_wr.seen", 64'(seen), 64'(1));
    check("rst_wr.addr", 64'(mem_addr), 64'(8'h90));
    reset = 1'b1;
    #1;
    check("rst_wr.outputs", all_out(), 64'(0));
    run = 1'b0;
    @(negedge clock);
    check("rst_wr.aborted", 64'(ram[8'h90]), 64'(model[8'h90]));
    reset = 1'b0;
    @(negedge clock);
    check("rst_wr.idle", 64'({mem_re, mem_we, ldr_gnt, cpu_step}), 64'(0));

    poke(8'h00, 8'h03); poke(8'h01, 8'h15); poke(8'h02, 8'h45); poke(8'h03, 8'h80);
    poke(8'h04, 8'h47); poke(8'h07, 8'hC3); poke(8'h85, 8'h3C); poke(8'h87, 8'h5B);

    // ALU instruction cycle by cycle, then run dropped mid-instruction.
    cpu_pc = 8'h00; run = 1'b1;
    @(negedge clock);
    check("alu.fetch", 64'({mem_re, mem_addr}), 64'({1'b1, 8'h00}));
    @(negedge clock);
    @(negedge clock);
    check("alu.instr", 64'(cpu_instr), 64'(8'h03));
    @(negedge clock);
    check("alu.step", 64'(cpu_step), 64'(1));
    cpu_pc = 8'h01; exp_count = 16'd1;
    @(negedge clock);
    check("alu.next_fetch", 64'({mem_re, mem_addr}), 64'({1'b1, 8'h01}));
    check("alu.count", 64'(instr_count), 64'(1));
    run = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clock);
      if (cpu_step) seen = 1;
    end
    check("stop.step_seen", 64'(seen), 64'(1));
    cpu_pc = 8'h02; exp_count = 16'd2;
    @(negedge clock);
    check("stop.idle", 64'({mem_re, mem_we, ldr_gnt, cpu_step}), 64'(0));
    check("stop.count", 64'(instr_count), 64'(2));

    // Load and store through the data window, including address wrap.
    cpu_endereco = 8'h05; run = 1'b1;
    run_one("load", 0, f);
    check("load.value", 64'(cpu_dado_lido), 64'(8'h3C));
    cpu_endereco = 8'h90; cpu_dado_escrita = 8'hA5;
    run_one("store", 0, f);
    check("store.ram", 64'(ram[8'h10]), 64'(8'hA5));

    // Loader request raised during a load's read wait.
    cpu_endereco = 8'h07;
    ldr_we = 1'b1; ldr_addr = 8'h02; ldr_wdata = 8'h77;
    run_one("ldr_mid", 1, f);
    @(negedge clock);
    check("ldr_mid.gnt", 64'({ldr_gnt, mem_we, mem_re, mem_addr, mem_wdata}),
          64'({1'b1, 1'b1, 1'b0, 8'h02, 8'h77}));
    ldr_req = 1'b0; model[8'h02] = 8'h77;
    @(negedge clock);
    check("ldr_mid.bubble", 64'({ldr_gnt, mem_re, mem_we}), 64'(0));
    cpu_endereco = 8'($urandom); cpu_dado_escrita = nc_byte();
    run_one("after_ldr", 0, f);
    check("after_ldr.fetch_at", 64'(f), 64'(1));
    run = 1'b0;

    ldr_op("ldr_rd", 1'b0, 8'h02, 8'h00, f);
    check("ldr_rd.value", 64'(ldr_rdata), 64'(8'h77));
    @(negedge clock);
    check("ldr_rd.pulse", 64'(ldr_valid), 64'(0));

    // Loader beats run in IDLE, then one bubble before fetch.
    run = 1'b1;
    ldr_op("prio", 1'b1, 8'hF0, nc_byte(), f);
    check("prio.gnt_at", 64'(f), 64'(1));
    cpu_endereco = 8'($urandom); cpu_dado_escrita = nc_byte();
    run_one("post_prio", 0, f);
    check("post_prio.fetch_at", 64'(f), 64'(2));

    // Load and store decoded together: read path only, sticky error.
    cpu_endereco = 8'($urandom); cpu_dado_escrita = nc_byte();
    run_one("proto", 0, f);

    for (int i = 0; i < 40; i++) begin
      cpu_endereco = 8'($urandom); cpu_dado_escrita = nc_byte();
      run_one("rand", 0, f);
      if ($urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 1) == 0) ldr_op("rand_ldr_wr", 1'b1, 8'($urandom), nc_byte(), f);
        else                           ldr_op("rand_ldr_rd", 1'b0, 8'($urandom), 8'h00, f);
      end
    end
    run = 1'b0;
    @(negedge clock);
    @(negedge clock);

    // Retire counter wrap from a preloaded value.
    force dut.instr_count = 16'hFFFE;
    #1;
    release dut.instr_count;
    exp_count = 16'hFFFE;
    run = 1'b1;
    cpu_endereco = 8'($urandom); cpu_dado_escrita = nc_byte();
    run_one("wrap1", 0, f);
    run_one("wrap2", 0, f);
    run = 1'b0;
    @(negedge clock);
    check("wrap.count", 64'(instr_count), 64'(0));

    reset = 1'b1;
    #1;
    check("final_reset", all_out(), 64'(0));
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
